// File: rtl/load_writeback_unit.sv
// load_writeback_unit
//   Issues one data-memory read at a time for a load instruction. It extracts
//   the addressed byte, half, word or dword from the returned 64-bit
//   little-endian beat, sign- or zero-extends it, and drives the register-file
//   load-writeback port. busy/busy_reg_a let the pipeline detect hazards
//   against the in-flight destination.
//
//   Parameters
//     WAIT_LIMIT  cycles allowed in WAIT before a timeout fault (1..65535)
//
//   Ports
//     clk, rst_n (async active-low), clk_en (global hold when low)
//     req_*       load request from the pipeline; req_ready = unit is idle
//     mem_req_*   aligned read request to data memory, mem_addr held until accepted
//     mem_rsp_*   read response (only honoured while waiting for one)
//     wload_*     register-file writeback strobe / register / value
//     busy*       in-flight indication and its destination register
//     fault*      one-cycle fault pulse; code 1=misaligned, 2=timeout (code is sticky)
//   All outputs except req_ready are registered.
module load_writeback_unit #(
  parameter int unsigned WAIT_LIMIT = 255
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        clk_en,
  input  logic        req_valid,
  output logic        req_ready,
  input  logic [63:0] req_addr,
  input  logic [1:0]  req_size,
  input  logic        req_signed,
  input  logic [4:0]  req_dest,
  output logic        mem_req_valid,
  input  logic        mem_req_ready,
  output logic [63:0] mem_addr,
  input  logic        mem_rsp_valid,
  input  logic [63:0] mem_rsp_data,
  output logic        wload_en,
  output logic [4:0]  wload_reg_a,
  output logic [63:0] wload_reg_v,
  output logic        busy,
  output logic [4:0]  busy_reg_a,
  output logic        fault,
  output logic [1:0]  fault_code
);

  typedef enum logic [2:0] {
    S_IDLE = 3'd0,
    S_REQ  = 3'd1,
    S_WAIT = 3'd2,
    S_WB   = 3'd3,
    S_FLT  = 3'd4
  } state_t;

  localparam logic [15:0] WAIT_LAST = 16'(WAIT_LIMIT - 1);
  localparam logic [4:0]  DISCARD_REG = 5'd31;

  state_t      r_state, w_state_nxt;
  logic [2:0]  r_off, w_off_nxt;
  logic [1:0]  r_size, w_size_nxt;
  logic        r_sgn, w_sgn_nxt;
  logic [4:0]  r_dest, w_dest_nxt;
  logic [15:0] r_wait_cnt, w_wait_cnt_nxt;

  logic        r_mem_req_valid, w_mem_req_valid_nxt;
  logic [63:0] r_mem_addr, w_mem_addr_nxt;
  logic        r_wload_en, w_wload_en_nxt;
  logic [4:0]  r_wload_reg_a, w_wload_reg_a_nxt;
  logic [63:0] r_wload_reg_v, w_wload_reg_v_nxt;
  logic        r_busy, w_busy_nxt;
  logic [4:0]  r_busy_reg_a, w_busy_reg_a_nxt;
  logic        r_fault, w_fault_nxt;
  logic [1:0]  r_fault_code, w_fault_code_nxt;

  // An access is misaligned when the low address bits are not a multiple
  // of the access size in bytes.
  function automatic logic is_misaligned(input logic [2:0] off, input logic [1:0] size);
    logic mis;
    case (size)
      2'd0:    mis = 1'b0;
      2'd1:    mis = off[0];
      2'd2:    mis = |off[1:0];
      default: mis = |off;
    endcase
    return mis;
  endfunction

  // Shift the addressed lane down to bit 0, then extend from the access width.
  function automatic logic [63:0] extract(input logic [63:0] data, input logic [2:0] off,
                                          input logic [1:0] size, input logic sgn);
    logic [63:0] sh;
    logic [63:0] val;
    sh = data >> {off, 3'b000};
    case (size)
      2'd0:    val = {{56{sgn & sh[7]}},  sh[7:0]};
      2'd1:    val = {{48{sgn & sh[15]}}, sh[15:0]};
      2'd2:    val = {{32{sgn & sh[31]}}, sh[31:0]};
      default: val = sh;
    endcase
    return val;
  endfunction

  always_comb begin
    w_state_nxt         = r_state;
    w_off_nxt           = r_off;
    w_size_nxt          = r_size;
    w_sgn_nxt           = r_sgn;
    w_dest_nxt          = r_dest;
    w_wait_cnt_nxt      = r_wait_cnt;
    w_mem_req_valid_nxt = r_mem_req_valid;
    w_mem_addr_nxt      = r_mem_addr;
    w_wload_en_nxt      = r_wload_en;
    w_wload_reg_a_nxt   = r_wload_reg_a;
    w_wload_reg_v_nxt   = r_wload_reg_v;
    w_busy_nxt          = r_busy;
    w_busy_reg_a_nxt    = r_busy_reg_a;
    w_fault_nxt         = r_fault;
    w_fault_code_nxt    = r_fault_code;

    case (r_state)
      S_IDLE: begin
        if (req_valid) begin
          w_off_nxt        = req_addr[2:0];
          w_size_nxt       = req_size;
          w_sgn_nxt        = req_signed;
          w_dest_nxt       = req_dest;
          w_busy_nxt       = 1'b1;
          w_busy_reg_a_nxt = req_dest;
          if (is_misaligned(req_addr[2:0], req_size)) begin
            w_state_nxt      = S_FLT;
            w_fault_nxt      = 1'b1;
            w_fault_code_nxt = 2'd1;
          end else begin
            w_state_nxt         = S_REQ;
            w_mem_req_valid_nxt = 1'b1;
            w_mem_addr_nxt      = {req_addr[63:3], 3'b000};
          end
        end
      end
      S_REQ: begin
        if (mem_req_ready) begin
          w_state_nxt         = S_WAIT;
          w_mem_req_valid_nxt = 1'b0;
          w_wait_cnt_nxt      = 16'd0;
        end
      end
      S_WAIT: begin
        // A response always beats the timeout in the same cycle.
        if (mem_rsp_valid) begin
          w_state_nxt       = S_WB;
          w_wload_en_nxt    = (r_dest != DISCARD_REG);
          w_wload_reg_a_nxt = r_dest;
          w_wload_reg_v_nxt = extract(mem_rsp_data, r_off, r_size, r_sgn);
        end else if (r_wait_cnt == WAIT_LAST) begin
          w_state_nxt      = S_FLT;
          w_fault_nxt      = 1'b1;
          w_fault_code_nxt = 2'd2;
        end else begin
          w_wait_cnt_nxt = r_wait_cnt + 16'd1;
        end
      end
      S_WB: begin
        w_state_nxt    = S_IDLE;
        w_wload_en_nxt = 1'b0;
        w_busy_nxt     = 1'b0;
      end
      S_FLT: begin
        w_state_nxt = S_IDLE;
        w_fault_nxt = 1'b0;
        w_busy_nxt  = 1'b0;
      end
      default: begin
        w_state_nxt = S_IDLE;
      end
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state         <= S_IDLE;
      r_off           <= 3'd0;
      r_size          <= 2'd0;
      r_sgn           <= 1'b0;
      r_dest          <= 5'd0;
      r_wait_cnt      <= 16'd0;
      r_mem_req_valid <= 1'b0;
      r_mem_addr      <= 64'd0;
      r_wload_en      <= 1'b0;
      r_wload_reg_a   <= 5'd0;
      r_wload_reg_v   <= 64'd0;
      r_busy          <= 1'b0;
      r_busy_reg_a    <= 5'd0;
      r_fault         <= 1'b0;
      r_fault_code    <= 2'd0;
    end else if (clk_en) begin
      r_state         <= w_state_nxt;
      r_off           <= w_off_nxt;
      r_size          <= w_size_nxt;
      r_sgn           <= w_sgn_nxt;
      r_dest          <= w_dest_nxt;
      r_wait_cnt      <= w_wait_cnt_nxt;
      r_mem_req_valid <= w_mem_req_valid_nxt;
      r_mem_addr      <= w_mem_addr_nxt;
      r_wload_en      <= w_wload_en_nxt;
      r_wload_reg_a   <= w_wload_reg_a_nxt;
      r_wload_reg_v   <= w_wload_reg_v_nxt;
      r_busy          <= w_busy_nxt;
      r_busy_reg_a    <= w_busy_reg_a_nxt;
      r_fault         <= w_fault_nxt;
      r_fault_code    <= w_fault_code_nxt;
    end
  end

  assign req_ready     = (r_state == S_IDLE);
  assign mem_req_valid = r_mem_req_valid;
  assign mem_addr      = r_mem_addr;
  assign wload_en      = r_wload_en;
  assign wload_reg_a   = r_wload_reg_a;
  assign wload_reg_v   = r_wload_reg_v;
  assign busy          = r_busy;
  assign busy_reg_a    = r_busy_reg_a;
  assign fault         = r_fault;
  assign fault_code    = r_fault_code;

endmodule

// File: tb/tb_load_writeback_unit.sv
// Testbench for load_writeback_unit: directed scenarios followed by random
// loads, with the bench acting as data memory and predicting every result
// from the access rules (byte lanes, extension, alignment, wait budget).
module tb_load_writeback_unit;

  localparam int WL = 4;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        clk_en;
  logic        req_valid;
  logic        req_ready;
  logic [63:0] req_addr;
  logic [1:0]  req_size;
  logic        req_signed;
  logic [4:0]  req_dest;
  logic        mem_req_valid;
  logic        mem_req_ready;
  logic [63:0] mem_addr;
  logic        mem_rsp_valid;
  logic [63:0] mem_rsp_data;
  logic        wload_en;
  logic [4:0]  wload_reg_a;
  logic [63:0] wload_reg_v;
  logic        busy;
  logic [4:0]  busy_reg_a;
  logic        fault;
  logic [1:0]  fault_code;

  int total = 0;
  int bad   = 0;

  load_writeback_unit #(.WAIT_LIMIT(WL)) dut (
    .clk(clk), .rst_n(rst_n), .clk_en(clk_en),
    .req_valid(req_valid), .req_ready(req_ready), .req_addr(req_addr),
    .req_size(req_size), .req_signed(req_signed), .req_dest(req_dest),
    .mem_req_valid(mem_req_valid), .mem_req_ready(mem_req_ready), .mem_addr(mem_addr),
    .mem_rsp_valid(mem_rsp_valid), .mem_rsp_data(mem_rsp_data),
    .wload_en(wload_en), .wload_reg_a(wload_reg_a), .wload_reg_v(wload_reg_v),
    .busy(busy), .busy_reg_a(busy_reg_a), .fault(fault), .fault_code(fault_code)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s got=%h exp=%h", tag, got, exp);
    end
  endtask

  // Assemble the loaded value byte by byte, then extend by arithmetic.
  function automatic logic [63:0] ref_load(input logic [63:0] data, input logic [2:0] off,
                                           input logic [1:0] size, input logic sgn);
    int n;
    logic [63:0] v;
    n = 1 << size;
    v = 64'd0;
    for (int i = n - 1; i >= 0; i--)
      v = (v << 8) | ((data >> (8 * (int'(off) + i))) & 64'hFF);
    if (sgn && v[8*n-1])
      v = v | (~64'd0 << (8 * n));
    return v;
  endfunction

  // One complete load; the bench is positioned at a negedge with the unit idle.
  task automatic do_load(input logic [63:0] addr, input logic [1:0] size, input logic sgn,
                         input logic [4:0] dest, input logic [63:0] data,
                         input int rdy_dly, input int rsp_dly);
    int n;
    logic mis;
    n   = 1 << size;
    mis = (int'(addr[2:0]) % n) != 0;
    chk("idle_ready", req_ready, 1);
    req_valid  = 1'b1;
    req_addr   = addr;
    req_size   = size;
    req_signed = sgn;
    req_dest   = dest;
    @(negedge clk);
    req_valid = 1'b0;
    req_addr  = {$urandom, $urandom};
    chk("busy", busy, 1);
    chk("busy_reg_a", busy_reg_a, 64'(dest));
    if (mis) begin
      chk("mis_fault", fault, 1);
      chk("mis_code", fault_code, 1);
      chk("mis_no_memreq", mem_req_valid, 0);
      chk("mis_no_wb", wload_en, 0);
      @(negedge clk);
      chk("mis_fault_clear", fault, 0);
      chk("mis_ready_after", req_ready, 1);
      chk("mis_busy_clear", busy, 0);
      return;
    end
    for (int i = 0; i <= rdy_dly; i++) begin
      chk("memreq_valid", mem_req_valid, 1);
      chk("mem_addr", mem_addr, {addr[63:3], 3'b000});
      chk("req_busy_reg", busy_reg_a, 64'(dest));
      mem_req_ready = (i == rdy_dly);
      mem_rsp_valid = 1'($urandom);
      mem_rsp_data  = {$urandom, $urandom};
      @(negedge clk);
      chk("req_no_wb", wload_en, 0);
    end
    mem_req_ready = 1'b0;
    chk("memreq_dropped", mem_req_valid, 0);
    for (int k = 0; k < WL; k++) begin
      mem_rsp_valid = (k == rsp_dly);
      mem_rsp_data  = (k == rsp_dly) ? data : {$urandom, $urandom};
      @(negedge clk);
      mem_rsp_valid = 1'b0;
      if (k == rsp_dly) begin
        chk("wb_en", wload_en, (dest != 5'd31));
        if (dest != 5'd31) begin
          chk("wb_reg_a", wload_reg_a, 64'(dest));
          chk("wb_reg_v", wload_reg_v, ref_load(data, addr[2:0], size, sgn));
        end
        chk("wb_busy", busy, 1);
        chk("wb_no_fault", fault, 0);
        @(negedge clk);
        chk("wb_en_clear", wload_en, 0);
        chk("wb_busy_clear", busy, 0);
        chk("wb_ready_after", req_ready, 1);
        return;
      end
      if (k == WL - 1) begin
        chk("to_fault", fault, 1);
        chk("to_code", fault_code, 2);
        chk("to_no_wb", wload_en, 0);
        // Late responses while in FLT and afterwards must be ignored.
        mem_rsp_valid = 1'b1;
        mem_rsp_data  = data;
        @(negedge clk);
        chk("to_fault_clear", fault, 0);
        chk("to_code_hold", fault_code, 2);
        chk("to_ready", req_ready, 1);
        chk("to_busy_clear", busy, 0);
        @(negedge clk);
        mem_rsp_valid = 1'b0;
        chk("late_rsp_no_wb", wload_en, 0);
        chk("late_rsp_idle", req_ready, 1);
        return;
      end
      chk("wait_no_wb", wload_en, 0);
      chk("wait_no_fault", fault, 0);
    end
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [63:0] a;
    logic [1:0]  sz;
    rst_n = 1'b0; clk_en = 1'b1;
    req_valid = 1'b0; req_addr = 64'd0; req_size = 2'd0; req_signed = 1'b0; req_dest = 5'd0;
    mem_req_ready = 1'b0; mem_rsp_valid = 1'b0; mem_rsp_data = 64'd0;
    #12;
    chk("rst_memreq", mem_req_valid, 0);
    chk("rst_wload_en", wload_en, 0);
    chk("rst_fault", fault, 0);
    chk("rst_code", fault_code, 0);
    chk("rst_busy", busy, 0);
    chk("rst_reg_a", wload_reg_a, 0);
    chk("rst_reg_v", wload_reg_v, 0);
    chk("rst_busy_reg_a", busy_reg_a, 0);
    chk("rst_mem_addr", mem_addr, 0);
    chk("rst_ready", req_ready, 1);
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);

    // Signed byte
    do_load(64'h1005, 2'd0, 1'b1, 5'd4, 64'h0000_8000_0000_0000, 0, 0);
    chk("tp_sbyte_val", wload_reg_v, 64'hFFFF_FFFF_FFFF_FF80);
    chk("tp_sbyte_reg", wload_reg_a, 4);
    // Unsigned word, then dword
    do_load(64'h2004, 2'd2, 1'b0, 5'd7, 64'hDEADBEEF_12345678, 0, 0);
    chk("tp_uword_val", wload_reg_v, 64'h0000_0000_DEAD_BEEF);
    do_load(64'h2000, 2'd3, 1'b0, 5'd7, 64'hDEADBEEF_12345678, 0, 0);
    chk("tp_dword_val", wload_reg_v, 64'hDEADBEEF_12345678);
    // Misaligned half
    do_load(64'h3007, 2'd1, 1'b0, 5'd9, 64'd0, 0, 0);
    // Discard destination with a 5-cycle memory stall
    do_load(64'h4010, 2'd3, 1'b0, 5'd31, 64'h1122334455667788, 5, 1);
    // Timeout with a late response
    do_load(64'h5008, 2'd2, 1'b1, 5'd3, 64'hFFFF0000FFFF0000, 0, WL);

    // Reset during WAIT
    req_valid = 1'b1; req_addr = 64'h6000; req_size = 2'd3; req_signed = 1'b0; req_dest = 5'd12;
    @(negedge clk);
    req_valid = 1'b0; mem_req_ready = 1'b1;
    @(negedge clk);
    mem_req_ready = 1'b0;
    chk("pre_rst_busy", busy, 1);
    #2 rst_n = 1'b0;
    #1;
    chk("mid_rst_busy", busy, 0);
    chk("mid_rst_busy_reg_a", busy_reg_a, 0);
    chk("mid_rst_memreq", mem_req_valid, 0);
    chk("mid_rst_mem_addr", mem_addr, 0);
    chk("mid_rst_reg_v", wload_reg_v, 0);
    chk("mid_rst_ready", req_ready, 1);
    @(negedge clk);
    rst_n = 1'b1;
    mem_rsp_valid = 1'b1; mem_rsp_data = 64'hABCD;
    @(negedge clk);
    mem_rsp_valid = 1'b0;
    chk("post_rst_no_wb", wload_en, 0);
    chk("post_rst_ready", req_ready, 1);

    // clk_en low for 3 cycles while in WB
    req_valid = 1'b1; req_addr = 64'h7002; req_size = 2'd1; req_signed = 1'b1; req_dest = 5'd20;
    @(negedge clk);
    req_valid = 1'b0; mem_req_ready = 1'b1;
    @(negedge clk);
    mem_req_ready = 1'b0; mem_rsp_valid = 1'b1; mem_rsp_data = 64'h0000_0000_9ABC_0000;
    @(negedge clk);
    mem_rsp_valid = 1'b0;
    chk("ce_wb_en", wload_en, 1);
    chk("ce_wb_val", wload_reg_v, 64'hFFFF_FFFF_FFFF_9ABC);
    clk_en = 1'b0;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      chk("ce_hold_en", wload_en, 1);
      chk("ce_hold_busy", busy, 1);
    end
    clk_en = 1'b1;
    @(negedge clk);
    chk("ce_single_wb", wload_en, 0);
    chk("ce_ready", req_ready, 1);

    // Random loads
    for (int t = 0; t < 150; t++) begin
      sz = 2'($urandom);
      a  = {$urandom, $urandom};
      if ($urandom_range(3) != 0)
        a[2:0] = a[2:0] & ~3'((1 << sz) - 1);
      do_load(a, sz, 1'($urandom), 5'($urandom), {$urandom, $urandom},
              $urandom_range(2), $urandom_range(5));
      if ($urandom_range(3) == 0) @(negedge clk);
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
